wb_write_sequencer: RTL and testbench

WB_WRITE_SEQUENCER -- requirements
Module: wb_write_sequencer

---
 rtl/wb_write_sequencer_if.sv | 34 +++
 rtl/wb_write_sequencer.sv | 168 ++++++++++++++++
 tb/tb_wb_write_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_write_sequencer_if.sv
// Request, debug and register-file write signals of the write-back sequencer.
// No storage of its own; pure signal bundle.
// Producer drives requests and debug writes, sequencer drives handshakes and rf port.
interface wb_write_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic        cond;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        dbg_req;
    logic [3:0]  dbg_addr;
    logic [63:0] dbg_data;
    logic        dbg_gnt;
    logic        rf_we;
    logic [3:0]  rf_addr;
    logic [63:0] rf_data;
    logic        busy;
    logic [15:0] wr_count;

    modport master (
        output in_valid, icode, rA, rB, cond, valE, valM,
        output dbg_req, dbg_addr, dbg_data,
        input  in_ready, dbg_gnt, rf_we, rf_addr, rf_data, busy, wr_count
    );

    modport slave (
        input  in_valid, icode, rA, rB, cond, valE, valM,
        input  dbg_req, dbg_addr, dbg_data,
        output in_ready, dbg_gnt, rf_we, rf_addr, rf_data, busy, wr_count
    );
endinterface

// File: rtl/wb_write_sequencer.sv
// Serialises Y86 write-back (E then M write) and debug writes onto one register-file write port.
// Latency: request accepted at edge N writes in cycle N+1; popq writes on two consecutive cycles.
// Backpressure: in_ready only in IDLE; debug is forced in after 4 consecutive accepts under dbg_req.
module wb_write_sequencer (
    input  logic                 clk,
    input  logic                 reset,
    wb_write_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WR_E, WR_M, WR_D} state_t;

    state_t      state;
    state_t      state_nxt;

    // Pending writes; WR_D reuses the E slot for the debug write.
    logic        e_vld;
    logic [3:0]  e_addr;
    logic [63:0] e_data;
    logic        m_vld;
    logic [3:0]  m_addr;
    logic [63:0] m_data;

    logic        dec_e_vld;
    logic [3:0]  dec_e_addr;
    logic [63:0] dec_e_data;
    logic        dec_m_vld;
    logic [3:0]  dec_m_addr;
    logic [63:0] dec_m_data;

    logic [2:0]  streak;
    logic        force_dbg;
    logic        accept;
    logic        grant;
    logic        in_ready;
    logic        rf_we;
    logic [3:0]  rf_addr;
    logic [63:0] rf_data;
    logic [15:0] wr_count;

    // A streak only matters while debug is still asking.
    assign force_dbg = (streak == 3'd4) && bus.dbg_req;

    // Decode the incoming request into its E/M write pair; index 0xF means "no register".
    always_comb begin
        dec_e_vld  = 1'b0;
        dec_e_addr = bus.rB;
        dec_e_data = bus.valE;
        dec_m_vld  = 1'b0;
        dec_m_addr = bus.rA;
        dec_m_data = bus.valM;
        case (bus.icode)
            4'h3, 4'h6: dec_e_vld = 1'b1;
            4'h2:       dec_e_vld = bus.cond;
            4'h5:       dec_m_vld = 1'b1;
            4'h8, 4'h9, 4'hA: begin
                dec_e_vld  = 1'b1;
                dec_e_addr = 4'h4;
            end
            4'hB: begin
                dec_e_vld  = 1'b1;
                dec_e_addr = 4'h4;
                dec_m_vld  = 1'b1;
            end
            default: ;
        endcase
        if (dec_e_addr == 4'hF) dec_e_vld = 1'b0;
        if (dec_m_addr == 4'hF) dec_m_vld = 1'b0;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state, arbitration and write-port drive; reset forces every output quiet.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        grant     = 1'b0;
        rf_we     = 1'b0;
        rf_addr   = 4'h0;
        rf_data   = 64'h0;
        case (state)
            IDLE: begin
                in_ready = !force_dbg;
                if (bus.in_valid && !force_dbg) begin
                    accept    = 1'b1;
                    state_nxt = dec_e_vld ? WR_E : (dec_m_vld ? WR_M : IDLE);
                end else if (bus.dbg_req) begin
                    grant     = 1'b1;
                    state_nxt = WR_D;
                end
            end
            WR_E: begin
                rf_we     = 1'b1;
                rf_addr   = e_addr;
                rf_data   = e_data;
                state_nxt = m_vld ? WR_M : IDLE;
            end
            WR_M: begin
                rf_we     = 1'b1;
                rf_addr   = m_addr;
                rf_data   = m_data;
                state_nxt = IDLE;
            end
            WR_D: begin
                rf_we     = e_vld;
                rf_addr   = e_vld ? e_addr : 4'h0;
                rf_data   = e_vld ? e_data : 64'h0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (reset) begin
            in_ready = 1'b0;
            accept   = 1'b0;
            grant    = 1'b0;
            rf_we    = 1'b0;
            rf_addr  = 4'h0;
            rf_data  = 64'h0;
        end
    end

    // Capture the decoded pair on accept, or the debug write on grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_vld  <= 1'b0;
            e_addr <= 4'h0;
            e_data <= 64'h0;
            m_vld  <= 1'b0;
            m_addr <= 4'h0;
            m_data <= 64'h0;
        end else if (accept) begin
            e_vld  <= dec_e_vld;
            e_addr <= dec_e_addr;
            e_data <= dec_e_data;
            m_vld  <= dec_m_vld;
            m_addr <= dec_m_addr;
            m_data <= dec_m_data;
        end else if (grant) begin
            e_vld  <= (bus.dbg_addr != 4'hF);
            e_addr <= bus.dbg_addr;
            e_data <= bus.dbg_data;
            m_vld  <= 1'b0;
        end
    end

    // Count accepts made while debug waits; saturates at the forcing threshold.
    always_ff @(posedge clk) begin
        if (reset || !bus.dbg_req || grant) streak <= 3'd0;
        else if (accept && streak != 3'd4)  streak <= streak + 3'd1;
    end

    // Running count of write-port cycles, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (reset)      wr_count <= 16'h0;
        else if (rf_we) wr_count <= wr_count + 16'd1;
    end

    assign bus.in_ready = in_ready;
    assign bus.dbg_gnt  = grant;
    assign bus.rf_we    = rf_we;
    assign bus.rf_addr  = rf_addr;
    assign bus.rf_data  = rf_data;
    assign bus.busy     = (state != IDLE) && !reset;
    assign bus.wr_count = wr_count;
endmodule

// File: tb/tb_wb_write_sequencer.sv
// Self-checking bench for wb_write_sequencer: request table plus multi-cycle corner sequences.
// Expected register writes are queued when stimulus is driven and popped on each rf_we.
// Outputs are sampled on the falling edge; inputs change on the falling edge or #1 after rising.
module tb_wb_write_sequencer;
    logic clk;
    logic reset;
    wb_write_sequencer_if bus();

    wb_write_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        cond;
        logic [63:0] val_e;
        logic [63:0] val_m;
        int          nw;
        logic [3:0]  a0;
        logic [63:0] d0;
        logic [3:0]  a1;
        logic [63:0] d1;
    } vec_t;

    vec_t        vecs[$];
    logic [67:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          wr_model = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write must match the oldest expected one; idle port must read zero.
    always @(negedge clk) begin
        if (reset) begin
            wr_model = 0;
        end else if (bus.rf_we) begin
            wr_model++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with nothing expected",
                         bus.rf_addr, bus.rf_data);
            end else begin
                logic [67:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", {60'h0, bus.rf_addr}, {60'h0, e[67:64]});
                chk("wr_data", bus.rf_data, e[63:0]);
            end
        end else begin
            chk("idle_addr_zero", {60'h0, bus.rf_addr}, 64'h0);
            chk("idle_data_zero", bus.rf_data, 64'h0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_vec(input vec_t v);
        if (v.nw >= 1) exp_q.push_back({v.a0, v.d0});
        if (v.nw >= 2) exp_q.push_back({v.a1, v.d1});
    endtask

    // Present one request and hold it until the rising edge that accepts it.
    task automatic send(input vec_t v);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready_timeout", {63'h0, bus.in_ready}, 64'h1);
        bus.icode    = v.icode;
        bus.rA       = v.ra;
        bus.rB       = v.rb;
        bus.cond     = v.cond;
        bus.valE     = v.val_e;
        bus.valM     = v.val_m;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_timeout", {63'h0, bus.busy}, 64'h0);
    endtask

    initial begin
        vec_t v;
        int   accepts, gnts, gnt_at, cyc;
        bit   drop;

        reset = 1'b1;
        bus.in_valid = 1'b1;
        bus.icode = 4'h6; bus.rA = 4'h0; bus.rB = 4'h1; bus.cond = 1'b0;
        bus.valE = 64'h0; bus.valM = 64'h0;
        bus.dbg_req = 1'b1; bus.dbg_addr = 4'h2; bus.dbg_data = 64'h0;

        // Reset holds every output low even with both requesters active.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {63'h0, bus.in_ready}, 64'h0);
        chk("rst_rf_we",    {63'h0, bus.rf_we},    64'h0);
        chk("rst_dbg_gnt",  {63'h0, bus.dbg_gnt},  64'h0);
        chk("rst_busy",     {63'h0, bus.busy},     64'h0);
        chk("rst_wr_count", {48'h0, bus.wr_count}, 64'h0);
        bus.in_valid = 1'b0;
        bus.dbg_req  = 1'b0;
        reset = 1'b0;

        // irmovq rB=3: one write in the cycle after accept, busy for that cycle only.
        v = '{4'h3, 4'hF, 4'h3, 1'b0, 64'h11, 64'h0, 1, 4'h3, 64'h11, 4'h0, 64'h0};
        push_vec(v);
        send(v);
        @(negedge clk);
        chk("lat_rf_we",   {63'h0, bus.rf_we}, 64'h1);
        chk("lat_rf_addr", {60'h0, bus.rf_addr}, 64'h3);
        chk("lat_rf_data", bus.rf_data, 64'h11);
        chk("lat_busy",    {63'h0, bus.busy}, 64'h1);
        @(negedge clk);
        chk("lat_busy_done", {63'h0, bus.busy}, 64'h0);
        chk("lat_wr_count",  {48'h0, bus.wr_count}, 64'h1);

        // popq rA=2: %rsp then rA on consecutive cycles, in_ready low throughout.
        v = '{4'hB, 4'h2, 4'hF, 1'b0, 64'h100, 64'hAB, 2, 4'h4, 64'h100, 4'h2, 64'hAB};
        push_vec(v);
        send(v);
        @(negedge clk);
        chk("pop_e_ready", {63'h0, bus.in_ready}, 64'h0);
        chk("pop_e_addr",  {60'h0, bus.rf_addr}, 64'h4);
        @(negedge clk);
        chk("pop_m_ready", {63'h0, bus.in_ready}, 64'h0);
        chk("pop_m_addr",  {60'h0, bus.rf_addr}, 64'h2);
        chk("pop_m_data",  bus.rf_data, 64'hAB);
        @(negedge clk);
        chk("pop_ready_back", {63'h0, bus.in_ready}, 64'h1);
        chk("pop_wr_count",   {48'h0, bus.wr_count}, 64'h3);

        // Decode table: icode, rA, rB, cond, valE, valM, writes, then expected writes.
        vecs.push_back('{4'h6, 4'h1, 4'h7, 1'b0, 64'hA1, 64'hB1, 1, 4'h7, 64'hA1, 4'h0, 64'h0});
        vecs.push_back('{4'h2, 4'h1, 4'h5, 1'b1, 64'hA2, 64'hB2, 1, 4'h5, 64'hA2, 4'h0, 64'h0});
        vecs.push_back('{4'h2, 4'h1, 4'h5, 1'b0, 64'hA3, 64'hB3, 0, 4'h0, 64'h0, 4'h0, 64'h0});
        vecs.push_back('{4'h1, 4'h1, 4'h5, 1'b1, 64'hA4, 64'hB4, 0, 4'h0, 64'h0, 4'h0, 64'h0});
        vecs.push_back('{4'h5, 4'h9, 4'h2, 1'b0, 64'hA5, 64'hB5, 1, 4'h9, 64'hB5, 4'h0, 64'h0});
        vecs.push_back('{4'hA, 4'h3, 4'hF, 1'b0, 64'hA6, 64'hB6, 1, 4'h4, 64'hA6, 4'h0, 64'h0});
        vecs.push_back('{4'h8, 4'hF, 4'hF, 1'b0, 64'hA7, 64'hB7, 1, 4'h4, 64'hA7, 4'h0, 64'h0});
        vecs.push_back('{4'h9, 4'hF, 4'hF, 1'b0, 64'hA8, 64'hB8, 1, 4'h4, 64'hA8, 4'h0, 64'h0});
        vecs.push_back('{4'hB, 4'h4, 4'hF, 1'b0, 64'hA9, 64'hB9, 2, 4'h4, 64'hA9, 4'h4, 64'hB9});
        vecs.push_back('{4'h5, 4'hF, 4'h3, 1'b0, 64'hAA, 64'hBA, 0, 4'h0, 64'h0, 4'h0, 64'h0});
        vecs.push_back('{4'h3, 4'h2, 4'hF, 1'b0, 64'hAB, 64'hBB, 0, 4'h0, 64'h0, 4'h0, 64'h0});
        vecs.push_back('{4'hB, 4'hF, 4'h1, 1'b0, 64'hAC, 64'hBC, 1, 4'h4, 64'hAC, 4'h0, 64'h0});
        vecs.push_back('{4'h0, 4'h1, 4'h2, 1'b1, 64'hAD, 64'hBD, 0, 4'h0, 64'h0, 4'h0, 64'h0});
        vecs.push_back('{4'h4, 4'h1, 4'h2, 1'b1, 64'hAE, 64'hBE, 0, 4'h0, 64'h0, 4'h0, 64'h0});
        vecs.push_back('{4'h7, 4'h1, 4'h2, 1'b1, 64'hAF, 64'hBF, 0, 4'h0, 64'h0, 4'h0, 64'h0});
        vecs.push_back('{4'h6, 4'h0, 4'hE, 1'b0, 64'hFFFF_0000_1234_5678, 64'h0, 1,
                         4'hE, 64'hFFFF_0000_1234_5678, 4'h0, 64'h0});

        foreach (vecs[i]) begin
            int base;
            base = wr_model;
            push_vec(vecs[i]);
            send(vecs[i]);
            @(negedge clk);
            chk($sformatf("vec%0d_busy", i), {63'h0, bus.busy}, {63'h0, vecs[i].nw > 0});
            chk($sformatf("vec%0d_ready", i), {63'h0, bus.in_ready}, {63'h0, vecs[i].nw == 0});
            wait_idle();
            chk($sformatf("vec%0d_writes", i), 64'(wr_model - base), 64'(vecs[i].nw));
            chk($sformatf("vec%0d_wr_count", i), {48'h0, bus.wr_count}, 64'(wr_model));
            chk($sformatf("vec%0d_queue", i), 64'(exp_q.size()), 64'h0);
        end

        // Debug write to 0xF: granted, but the write port stays quiet.
        begin
            int base;
            base = wr_model;
            @(negedge clk);
            bus.dbg_addr = 4'hF;
            bus.dbg_data = 64'h55;
            bus.dbg_req  = 1'b1;
            #1 chk("dbgF_gnt", {63'h0, bus.dbg_gnt}, 64'h1);
            @(posedge clk);
            #1 bus.dbg_req = 1'b0;
            @(negedge clk);
            chk("dbgF_no_we", {63'h0, bus.rf_we}, 64'h0);
            chk("dbgF_gnt_pulse", {63'h0, bus.dbg_gnt}, 64'h0);
            @(negedge clk);
            wait_idle();
            chk("dbgF_wr_count", {48'h0, bus.wr_count}, 64'(base));
        end

        // Fairness: continuous OPq with debug held; debug must win after the fourth accept.
        @(negedge clk);
        bus.dbg_req = 1'b1; bus.dbg_addr = 4'h6; bus.dbg_data = 64'hD0D0;
        bus.icode = 4'h6; bus.rB = 4'h8; bus.rA = 4'h1; bus.cond = 1'b0;
        bus.in_valid = 1'b1;
        accepts = 0; gnts = 0; gnt_at = -1; cyc = 0; drop = 1'b0;
        while (accepts < 6 && cyc < 100) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            if (drop) begin
                bus.dbg_req = 1'b0;
                drop = 1'b0;
            end
            #1;
            if (bus.dbg_gnt) begin
                gnts++;
                gnt_at = accepts;
                chk("fair_gnt_ready_low", {63'h0, bus.in_ready}, 64'h0);
                exp_q.push_back({4'h6, 64'hD0D0});
                drop = 1'b1;
            end
            if (bus.in_ready) begin
                bus.valE = 64'h1000 + 64'(accepts);
                exp_q.push_back({4'h8, bus.valE});
                accepts++;
            end
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        bus.dbg_req = 1'b0;
        @(negedge clk);
        wait_idle();
        chk("fair_accepts", 64'(accepts), 64'h6);
        chk("fair_gnt_after", 64'(gnt_at), 64'h4);
        chk("fair_gnt_count", 64'(gnts), 64'h1);
        chk("fair_queue", 64'(exp_q.size()), 64'h0);

        // Reset during the %rsp write of popq: nothing reaches the write port.
        v = '{4'hB, 4'h3, 4'hF, 1'b0, 64'h777, 64'h888, 0, 4'h0, 64'h0, 4'h0, 64'h0};
        send(v);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_we",    {63'h0, bus.rf_we}, 64'h0);
        chk("mid_rst_addr",  {60'h0, bus.rf_addr}, 64'h0);
        chk("mid_rst_data",  bus.rf_data, 64'h0);
        chk("mid_rst_busy",  {63'h0, bus.busy}, 64'h0);
        chk("mid_rst_ready", {63'h0, bus.in_ready}, 64'h0);
        @(negedge clk);
        chk("mid_rst_count", {48'h0, bus.wr_count}, 64'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_busy",  {63'h0, bus.busy}, 64'h0);
        chk("post_rst_count", {48'h0, bus.wr_count}, 64'h0);
        chk("post_rst_ready", {63'h0, bus.in_ready}, 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
